// File: rtl/keypad_lock_ctrl.sv
// Keypad PIN lock: decodes one-hot key scans, collects and checks a BCD PIN,
// tracks failed attempts with lockout, optional auto-relock, and buzzer tones.
module keypad_lock_ctrl #(
  parameter int unsigned             PIN_DIGITS   = 3,
  parameter logic [4*PIN_DIGITS-1:0] PIN          = 12'h246,
  parameter logic [4*PIN_DIGITS-1:0] PASS_PATTERN = 12'hBCC,
  parameter int unsigned             MAX_TRIES    = 6,
  parameter int unsigned             RELOCK_CYC   = 0,
  parameter int unsigned             CLICK_HALF   = 50000,
  parameter int unsigned             CLICK_LEN    = 10000000,
  parameter int unsigned             OK_HALF      = 25000,
  parameter int unsigned             OK_LEN       = 30000000,
  parameter int unsigned             FAIL_HALF    = 100000,
  parameter int unsigned             FAIL_LEN     = 15000000
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [15:0]                       i_onehot,
  output logic [4*PIN_DIGITS-1:0]           o_display,
  output logic [$clog2(PIN_DIGITS+1)-1:0]   o_digits,
  output logic [$clog2(MAX_TRIES+1)-1:0]    o_tries,
  output logic                              o_unlocked,
  output logic                              o_locked,
  output logic                              o_buzzer
);

  localparam int unsigned DW  = 4 * PIN_DIGITS;
  localparam int unsigned DGW = $clog2(PIN_DIGITS + 1);
  localparam int unsigned TW  = $clog2(MAX_TRIES + 1);
  localparam int unsigned LenMax0 = (CLICK_LEN > OK_LEN) ? CLICK_LEN : OK_LEN;
  localparam int unsigned LenMax  = (LenMax0 > FAIL_LEN) ? LenMax0 : FAIL_LEN;
  localparam int unsigned HalfMax0 = (CLICK_HALF > OK_HALF) ? CLICK_HALF : OK_HALF;
  localparam int unsigned HalfMax  = (HalfMax0 > FAIL_HALF) ? HalfMax0 : FAIL_HALF;
  localparam int unsigned CW = $clog2(LenMax + 1);
  localparam int unsigned HW = $clog2(HalfMax + 1);
  localparam int unsigned RW = (RELOCK_CYC > 1) ? $clog2(RELOCK_CYC) : 1;
  localparam int unsigned RelockLast = (RELOCK_CYC > 0) ? RELOCK_CYC - 1 : 0;
  localparam bit          RelockEn   = (RELOCK_CYC > 0);

  localparam logic [3:0] KeyEnter = 4'd10;
  localparam logic [3:0] KeyClear = 4'd11;
  localparam logic [3:0] KeyAdmin = 4'd12;
  localparam logic [3:0] KeyNone  = 4'd15;

  localparam logic [DW-1:0] Blank = {PIN_DIGITS{4'hF}};

  typedef enum logic [1:0] {StEntry, StOpen, StLockout} state_e;
  typedef enum logic [1:0] {ToneIdle, ToneClick, ToneOk, ToneFail} tone_e;

  logic [15:0]    r_onehot;
  logic [3:0]     r_key_prev;
  state_e         r_state;
  logic [DW-1:0]  r_display;
  logic [DGW-1:0] r_digits;
  logic [TW-1:0]  r_tries;
  logic [RW-1:0]  r_relock_cnt;
  tone_e          r_tone;
  logic [CW-1:0]  r_tone_cnt;
  logic [HW-1:0]  r_half_cnt;
  logic           r_phase;

  logic [3:0]     w_key;
  logic           w_event;
  logic           w_is_digit;
  logic           w_full;
  state_e         w_state_nxt;
  logic [DW-1:0]  w_display_nxt;
  logic [DGW-1:0] w_digits_nxt;
  logic [TW-1:0]  w_tries_nxt;
  tone_e          w_tone_req;
  tone_e          w_tone_nxt;
  logic [CW-1:0]  w_tone_cnt_nxt;
  logic [HW-1:0]  w_half_cnt_nxt;
  logic           w_phase_nxt;
  logic [CW-1:0]  w_len_m1;
  logic [HW-1:0]  w_half_m1;
  logic           w_mute;

  always_comb begin
    w_key = KeyNone;
    case (r_onehot)
      16'h0008: w_key = 4'd0;
      16'h0080: w_key = 4'd1;
      16'h0040: w_key = 4'd2;
      16'h0020: w_key = 4'd3;
      16'h0800: w_key = 4'd4;
      16'h0400: w_key = 4'd5;
      16'h0200: w_key = 4'd6;
      16'h8000: w_key = 4'd7;
      16'h4000: w_key = 4'd8;
      16'h2000: w_key = 4'd9;
      16'h0001: w_key = KeyEnter;
      16'h1000: w_key = KeyClear;
      16'h0100: w_key = KeyAdmin;
      default:  w_key = KeyNone;
    endcase
  end

  // A key only counts when it follows an idle scan; key-to-key slides are ignored.
  assign w_event    = (w_key != KeyNone) && (r_key_prev == KeyNone);
  assign w_is_digit = (w_key <= 4'd9);
  assign w_full     = (r_digits == DGW'(PIN_DIGITS));

  always_comb begin
    w_state_nxt   = r_state;
    w_display_nxt = r_display;
    w_digits_nxt  = r_digits;
    w_tries_nxt   = r_tries;
    w_tone_req    = ToneIdle;
    case (r_state)
      StEntry: begin
        if (w_event) begin
          if (w_is_digit) begin
            if (!w_full) begin
              w_display_nxt = (r_display << 4) | DW'(w_key);
              w_digits_nxt  = r_digits + DGW'(1);
              w_tone_req    = ToneClick;
            end
          end else if (w_key == KeyClear) begin
            w_display_nxt = Blank;
            w_digits_nxt  = '0;
            w_tone_req    = ToneClick;
          end else if (w_key == KeyAdmin) begin
            w_display_nxt = Blank;
            w_digits_nxt  = '0;
            w_tries_nxt   = '0;
            w_tone_req    = ToneClick;
          end else if (w_key == KeyEnter && w_full) begin
            if (r_display == PIN) begin
              w_state_nxt   = StOpen;
              w_display_nxt = PASS_PATTERN;
              w_tone_req    = ToneOk;
            end else begin
              w_tone_req    = ToneFail;
              w_digits_nxt  = '0;
              w_tries_nxt   = r_tries + TW'(1);
              w_display_nxt = Blank;
              if (r_tries == TW'(MAX_TRIES - 1)) begin
                w_state_nxt   = StLockout;
                w_display_nxt = '0;
              end
            end
          end
        end
      end
      StOpen: begin
        if (w_event && (w_key == KeyClear || w_key == KeyAdmin)) begin
          w_state_nxt   = StEntry;
          w_display_nxt = Blank;
          w_digits_nxt  = '0;
          w_tries_nxt   = '0;
          w_tone_req    = ToneClick;
        end else if (RelockEn && r_relock_cnt == RW'(RelockLast)) begin
          w_state_nxt   = StEntry;
          w_display_nxt = Blank;
          w_digits_nxt  = '0;
        end
      end
      StLockout: begin
        if (w_event && w_key == KeyAdmin) begin
          w_state_nxt   = StEntry;
          w_display_nxt = Blank;
          w_digits_nxt  = '0;
          w_tries_nxt   = '0;
          w_tone_req    = ToneClick;
        end
      end
      default: w_state_nxt = StEntry;
    endcase
  end

  always_comb begin
    w_len_m1  = CW'(CLICK_LEN - 1);
    w_half_m1 = HW'(CLICK_HALF - 1);
    case (r_tone)
      ToneOk: begin
        w_len_m1  = CW'(OK_LEN - 1);
        w_half_m1 = HW'(OK_HALF - 1);
      end
      ToneFail: begin
        w_len_m1  = CW'(FAIL_LEN - 1);
        w_half_m1 = HW'(FAIL_HALF - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_tone_nxt     = r_tone;
    w_tone_cnt_nxt = r_tone_cnt;
    w_half_cnt_nxt = r_half_cnt;
    w_phase_nxt    = r_phase;
    if (w_tone_req != ToneIdle) begin
      w_tone_nxt     = w_tone_req;
      w_tone_cnt_nxt = '0;
      w_half_cnt_nxt = '0;
      w_phase_nxt    = 1'b1;
    end else if (r_tone != ToneIdle) begin
      if (r_tone_cnt == w_len_m1) begin
        w_tone_nxt     = ToneIdle;
        w_tone_cnt_nxt = '0;
        w_half_cnt_nxt = '0;
        w_phase_nxt    = 1'b0;
      end else begin
        w_tone_cnt_nxt = r_tone_cnt + CW'(1);
        if (r_half_cnt == w_half_m1) begin
          w_half_cnt_nxt = '0;
          w_phase_nxt    = ~r_phase;
        end else begin
          w_half_cnt_nxt = r_half_cnt + HW'(1);
        end
      end
    end
  end

  // Fail tone is silent across its middle third.
  assign w_mute = (r_tone == ToneFail) && (r_tone_cnt >= CW'(FAIL_LEN / 3)) &&
                  (r_tone_cnt < CW'((2 * FAIL_LEN) / 3));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_onehot     <= '0;
      r_key_prev   <= KeyNone;
      r_state      <= StEntry;
      r_display    <= Blank;
      r_digits     <= '0;
      r_tries      <= '0;
      r_relock_cnt <= '0;
      r_tone       <= ToneIdle;
      r_tone_cnt   <= '0;
      r_half_cnt   <= '0;
      r_phase      <= 1'b0;
    end else begin
      r_onehot     <= i_onehot;
      r_key_prev   <= w_key;
      r_state      <= w_state_nxt;
      r_display    <= w_display_nxt;
      r_digits     <= w_digits_nxt;
      r_tries      <= w_tries_nxt;
      r_relock_cnt <= (r_state == StOpen) ? r_relock_cnt + RW'(1) : '0;
      r_tone       <= w_tone_nxt;
      r_tone_cnt   <= w_tone_cnt_nxt;
      r_half_cnt   <= w_half_cnt_nxt;
      r_phase      <= w_phase_nxt;
    end
  end

  assign o_display  = r_display;
  assign o_digits   = r_digits;
  assign o_tries    = r_tries;
  assign o_unlocked = (r_state == StOpen);
  assign o_locked   = (r_state == StLockout);
  assign o_buzzer   = (r_tone != ToneIdle) && r_phase && !w_mute;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed scenarios plus random key traffic,
// every cycle compared against an entry-queue / tone-timestamp reference model.
module tb_keypad_lock_ctrl;

  localparam int ND   = 3;
  localparam int MT   = 6;
  localparam int RC   = 20;
  localparam int HALF = 2;
  localparam int LEN  = 12;
  localparam int PIN_VAL  = 'h246;
  localparam int PASS_VAL = 'hBCC;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] onehot;
  logic [11:0] display;
  logic [1:0]  digits;
  logic [2:0]  tries;
  logic        unlocked, locked, buzzer;

  always #5 clk = ~clk;

  keypad_lock_ctrl #(
    .PIN_DIGITS  (ND),
    .PIN         (12'h246),
    .PASS_PATTERN(12'hBCC),
    .MAX_TRIES   (MT),
    .RELOCK_CYC  (RC),
    .CLICK_HALF  (HALF),
    .CLICK_LEN   (LEN),
    .OK_HALF     (HALF),
    .OK_LEN      (LEN),
    .FAIL_HALF   (HALF),
    .FAIL_LEN    (LEN)
  ) u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_onehot  (onehot),
    .o_display (display),
    .o_digits  (digits),
    .o_tries   (tries),
    .o_unlocked(unlocked),
    .o_locked  (locked),
    .o_buzzer  (buzzer)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Key value per one-hot bit position: 0-9 digits, 10 ENTER, 11 CLEAR, 12 ADMIN, -1 none.
  int kmap [16] = '{10, -1, -1, 0, -1, 3, 2, 1, 12, 6, 5, 4, 11, 9, 8, 7};

  // Reference model state
  int          m_cyc;
  logic [15:0] m_oh;
  int          m_last;
  int          m_entry[$];
  int          m_mode;     // 0 entry, 1 open, 2 lockout
  int          m_tries;
  int          m_open_at;
  int          m_tone;     // 0 idle, 1 click, 2 ok, 3 fail
  int          m_tone_at;

  function automatic int key_of(input logic [15:0] oh);
    if ($countones(oh) != 1) return -1;
    for (int i = 0; i < 16; i++) if (oh[i]) return kmap[i];
    return -1;
  endfunction

  function automatic logic [15:0] oh_of(input int k);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) if (kmap[i] == k) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_oh = '0; m_last = -1; m_entry.delete(); m_mode = 0; m_tries = 0;
    m_open_at = 0; m_tone = 0; m_tone_at = 0;
  endtask

  task automatic start_tone(input int kind);
    m_tone = kind;
    m_tone_at = m_cyc;
  endtask

  task automatic model_edge(input logic [15:0] oh, input logic r);
    int k, ev, val;
    m_cyc++;
    if (r) begin
      model_reset();
      return;
    end
    k = key_of(m_oh);
    ev = (k >= 0 && m_last < 0) ? k : -1;
    m_last = k;
    m_oh = oh;
    case (m_mode)
      0: begin
        if (ev >= 0 && ev <= 9) begin
          if (m_entry.size() < ND) begin
            m_entry.push_back(ev);
            start_tone(1);
          end
        end else if (ev == 11) begin
          m_entry.delete(); start_tone(1);
        end else if (ev == 12) begin
          m_entry.delete(); m_tries = 0; start_tone(1);
        end else if (ev == 10 && m_entry.size() == ND) begin
          val = 0;
          foreach (m_entry[i]) val = val * 16 + m_entry[i];
          if (val == PIN_VAL) begin
            m_mode = 1; m_open_at = m_cyc; start_tone(2);
          end else begin
            m_tries++; m_entry.delete(); start_tone(3);
            if (m_tries == MT) m_mode = 2;
          end
        end
      end
      1: begin
        if (ev == 11 || ev == 12) begin
          m_mode = 0; m_entry.delete(); m_tries = 0; start_tone(1);
        end else if (m_cyc - m_open_at == RC) begin
          m_mode = 0; m_entry.delete();
        end
      end
      default: begin
        if (ev == 12) begin
          m_mode = 0; m_entry.delete(); m_tries = 0; start_tone(1);
        end
      end
    endcase
  endtask

  function automatic logic [11:0] exp_display();
    logic [11:0] d;
    if (m_mode == 1) return 12'(PASS_VAL);
    if (m_mode == 2) return 12'h000;
    d = 12'hFFF;
    foreach (m_entry[i]) d = (d << 4) | 12'(m_entry[i]);
    return d;
  endfunction

  function automatic logic exp_buzzer();
    int e;
    if (m_tone == 0) return 1'b0;
    e = m_cyc - m_tone_at;
    if (e >= LEN) return 1'b0;
    if (m_tone == 3 && e >= LEN / 3 && e < (2 * LEN) / 3) return 1'b0;
    return ((e / HALF) % 2) == 0;
  endfunction

  task automatic step(input logic [15:0] oh, input logic r);
    @(negedge clk);
    onehot = oh;
    rst = r;
    @(posedge clk);
    model_edge(oh, r);
    #1;
    check("display", display, exp_display());
    check("digits", digits, m_entry.size());
    check("tries", tries, m_tries);
    check("unlocked", unlocked, m_mode == 1);
    check("locked", locked, m_mode == 2);
    check("buzzer", buzzer, exp_buzzer());
  endtask

  task automatic press(input int k, input int hold, input int gap);
    repeat (hold) step(oh_of(k), 1'b0);
    repeat (gap) step(16'h0000, 1'b0);
  endtask

  task automatic enter3(input int a, input int b, input int c);
    press(a, 3, 3); press(b, 3, 3); press(c, 3, 3); press(10, 3, 3);
  endtask

  initial begin
    int r, k;
    logic [15:0] oh;
    m_cyc = 0;
    model_reset();
    onehot = '0;
    rst = 1'b1;
    step(16'h0000, 1'b1);
    step(16'h0000, 1'b1);
    check("rst_display", display, 12'hFFF);
    check("rst_buzzer", buzzer, 1'b0);
    step(16'h0000, 1'b0);

    // Correct PIN unlocks
    press(2, 3, 3); check("t1_d1", display, 12'hFF2);
    press(4, 3, 3); check("t1_d2", display, 12'hF24);
    press(6, 3, 3); check("t1_d3", display, 12'h246);
    press(10, 3, 3);
    check("t1_unlocked", unlocked, 1'b1);
    check("t1_pass", display, 12'hBCC);
    press(11, 3, 12);

    // Six failures lock out, only ADMIN recovers
    for (int i = 0; i < MT; i++) begin
      enter3(1, 3, 5);
      check("t2_tries", tries, i + 1);
      repeat (6) step(16'h0000, 1'b0);
    end
    check("t2_locked", locked, 1'b1);
    check("t2_zero", display, 12'h000);
    press(2, 3, 3);
    check("t2_ignored", display, 12'h000);
    press(12, 3, 3);
    check("t2_admin_locked", locked, 1'b0);
    check("t2_admin_tries", tries, 3'd0);
    check("t2_admin_disp", display, 12'hFFF);

    // CLEAR mid-entry, then unlock
    press(1, 3, 3); press(2, 3, 3); press(11, 3, 3);
    check("t3_clear", display, 12'hFFF);
    enter3(2, 4, 6);
    check("t3_unlocked", unlocked, 1'b1);
    press(11, 3, 12);

    // Multi-hot and key slide produce no event
    repeat (3) step(16'h0009, 1'b0);
    repeat (3) step(16'h0000, 1'b0);
    check("t4_multihot", display, 12'hFFF);
    repeat (3) step(16'h0008, 1'b0);
    repeat (3) step(16'h0080, 1'b0);
    repeat (3) step(16'h0000, 1'b0);
    check("t4_slide_disp", display, 12'hFF0);
    check("t4_slide_digits", digits, 2'd1);
    press(11, 3, 3);

    // Auto-relock keeps tries
    enter3(9, 9, 9);
    enter3(2, 4, 6);
    check("t5_open", unlocked, 1'b1);
    repeat (RC) step(16'h0000, 1'b0);
    check("t5_relocked", unlocked, 1'b0);
    check("t5_disp", display, 12'hFFF);
    check("t5_tries", tries, 3'd1);

    // Reset mid fail tone, then mid entry
    press(1, 3, 3); press(3, 3, 3); press(5, 3, 3); press(10, 2, 2);
    step(16'h0000, 1'b1);
    check("t6a_buzzer", buzzer, 1'b0);
    check("t6a_tries", tries, 3'd0);
    check("t6a_disp", display, 12'hFFF);
    press(7, 3, 3); press(8, 2, 0);
    step(16'h0000, 1'b1);
    check("t6b_digits", digits, 2'd0);
    check("t6b_disp", display, 12'hFFF);
    check("t6b_buzzer", buzzer, 1'b0);
    step(16'h0000, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        step(16'h0000, 1'b1);
      end else if (r < 8) begin
        repeat (RC + 2) step(16'h0000, 1'b0);
      end else if (r < 18) begin
        oh = 16'($urandom);
        repeat ($urandom_range(1, 3)) step(oh, 1'b0);
        repeat ($urandom_range(0, 2)) step(16'h0000, 1'b0);
      end else if (r < 28) begin
        press(2, $urandom_range(1, 2), $urandom_range(1, 2));
        press(4, $urandom_range(1, 2), $urandom_range(1, 2));
        press(6, $urandom_range(1, 2), $urandom_range(1, 2));
        press(10, $urandom_range(1, 2), $urandom_range(1, 2));
      end else begin
        k = $urandom_range(0, 12);
        press(k, $urandom_range(1, 4), $urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
